branch_resolve: RTL and testbench
=================================

# branch_resolve

Execute-stage branch resolution unit for the RISC-V core. Sits directly around the branch comparator: drives its unsigned-select input from the instruction's funct3, consumes its equal/less-than results, and decides whether the branch is taken. It compares that decision with the fetch-stage prediction, issues a registered PC redirect on a mispredict, and squashes wrong-path instructions for a fixed window. It also keeps saturating branch and mispredict counters for CSR readout.

## Interface
- `PC_W`, default 32: PC and immediate width.
- `CNT_W`, default 32: statistics counter width.
- `KILL_CYCLES`, default 2: wrong-path instructions squashed after a redirect, range 1..7.

- `clk` input 1: core clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `stall` input 1: pipeline stall; freezes all state.
- `ex_valid` input 1: execute-stage instruction is valid.
- `ex_is_branch` input 1: instruction is a conditional branch (opcode 1100011).
- `ex_funct3` input 3: branch funct3.
- `ex_pred_taken` input 1: prediction carried from fetch.
- `ex_pc` input PC_W: branch PC.
- `ex_imm` input PC_W: sign-extended B-immediate.
- `brun` output 1: combinational; 1 when funct3 is 110 or 111, else 0.
- `breq` input 1: equality result from the comparator.
- `brlt` input 1: less-than result from the comparator.
- `counter_clr` input 1: synchronous clear of both counters.
- `redirect_valid` output 1: registered, single-cycle redirect pulse.
- `redirect_pc` output PC_W: registered redirect target.
- `kill` output 1: registered; squash the instruction currently in execute.
- `br_taken` output 1: combinational resolved direction (debug).
- `br_count` output CNT_W: count of resolved branches.
- `mispred_count` output CNT_W: count of mispredicted branches.

## Operation
- Resolve condition: `ex_valid & ex_is_branch & ~kill & ~stall`.
- Taken decision by funct3:
  - 000: breq
  - 001: ~breq
  - 100 and 110: brlt
  - 101 and 111: ~brlt
  - 010 and 011 (illegal): not taken
- `br_taken` is 0 whenever the resolve condition is false.
- Mispredict when `br_taken != ex_pred_taken`.
- Target on a mispredict: `ex_pc + ex_imm` if taken, otherwise `ex_pc + 4`. Addition is modulo 2^PC_W, so wrap-around is allowed.
- State machine:
  - IDLE to KILL on a mispredict. Load `kill_cnt = KILL_CYCLES`, pulse `redirect_valid`, and register `redirect_pc`.
  - KILL: `kill` = 1. `kill_cnt` decrements on each non-stalled cycle. Return to IDLE when it goes from 1 to 0.
  - Branches presented during KILL are wrong-path. They are ignored: no redirect, no counting.
- Counters:
  - `br_count` increments on every resolve.
  - `mispred_count` increments on every mispredict.
  - Both saturate at 2^CNT_W−1.
  - `counter_clr` has priority over a same-cycle increment; the result is 0.
- Stall: no resolve and no counting. `kill_cnt`, state, and counters hold. A pending `redirect_valid` pulse still lasts exactly one clock; it is not stretched by stall.

## Timing
- Reset values, applied on the first rising edge with `rst_n`=0: state IDLE, `redirect_valid` 0, `redirect_pc` 0, `kill` 0, `kill_cnt` 0, `br_count` 0, `mispred_count` 0. A reset during KILL returns to IDLE immediately.
- Latency: a branch resolving in cycle N gives `redirect_valid`=1 and `kill`=1 in cycle N+1.
- `kill` stays high for exactly KILL_CYCLES non-stalled cycles, from N+1 through N+KILL_CYCLES. With no stalls it is low again in N+KILL_CYCLES+1.
- Counters show an update one cycle after the resolve.
- `brun`, `br_taken` and the mispredict decision are purely combinational within the cycle. No registered path feeds back into the comparator.

## Test plan
- BLT with rs1=0xFFFFFFFF and rs2=1: comparator gives brlt=1 with brun=0. With pred=0, pc=0x100 and imm=0x40, expect `redirect_valid` pulse with `redirect_pc`=0x140 in N+1, `kill` high for 2 cycles, and both counters equal to 1.
- BGEU with funct3 111 and brlt=1, pred=1, pc=0x200: expect `brun`=1, not taken, mispredict, and `redirect_pc`=0x204.
- Correctly predicted BEQ with breq=1 and pred=1: expect no redirect, `kill` 0, `br_count` +1, and `mispred_count` unchanged.
- Mispredict, then a second mispredicting branch presented during KILL: expect only one redirect and `br_count`=1. Insert `stall` for 3 cycles mid-KILL: expect `kill` to last 2+3 cycles.
- Counter saturation with CNT_W=4: resolve 20 mispredicting branches spaced by kill windows. Expect both counters stuck at 15. Then assert `counter_clr` together with a resolve: expect 0.
- Mispredict followed by `rst_n`=0 in N+1: expect `kill`, `redirect_valid` and both counters to be 0 the following cycle. Also verify funct3 010 resolves as not taken.

Source files
------------

// File: rtl/branch_resolve_if.sv
// Execute-stage branch bus between the pipeline and the branch resolution unit.
//
// Handshake: ex_valid qualifies every ex_* field in the cycle it is high. There
// is no ready signal. The only back-pressure is the core-wide stall input on the
// unit, and the unit never holds off a valid instruction. redirect_valid is a
// one-cycle pulse qualifying redirect_pc. Fetch must accept it in that cycle.
// kill squashes whatever instruction occupies execute in the current cycle.
interface branch_resolve_if #(
    parameter int PC_W = 32
);
    logic            ex_valid;
    logic            ex_is_branch;
    logic [2:0]      ex_funct3;
    logic            ex_pred_taken;
    logic [PC_W-1:0] ex_pc;
    logic [PC_W-1:0] ex_imm;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            kill;

    // Pipeline side: presents the branch, receives redirect/kill.
    modport master (
        output ex_valid, ex_is_branch, ex_funct3, ex_pred_taken, ex_pc, ex_imm,
        input  redirect_valid, redirect_pc, kill
    );

    // Resolution unit side.
    modport slave (
        input  ex_valid, ex_is_branch, ex_funct3, ex_pred_taken, ex_pc, ex_imm,
        output redirect_valid, redirect_pc, kill
    );
endinterface

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: decodes funct3 against the comparator
// results, detects mispredicts, issues a registered redirect and squashes the
// wrong-path window. It also keeps saturating branch/mispredict counters.
module branch_resolve #(
    parameter int PC_W        = 32,
    parameter int CNT_W       = 32,
    parameter int KILL_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    branch_resolve_if.slave  ex_if,
    output logic             brun,
    input  logic             breq,
    input  logic             brlt,
    input  logic             counter_clr,
    output logic             br_taken,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count,
    output logic             state_dbg
);
    typedef enum logic {S_IDLE = 1'b0, S_KILL = 1'b1} state_t;

    localparam logic [2:0] KILL_INIT = 3'(KILL_CYCLES);

    state_t            state_q, state_d;
    logic [2:0]        kill_cnt_q, kill_cnt_d;
    logic              kill_q, kill_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0]   redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]  br_count_q, br_count_d;
    logic [CNT_W-1:0]  mispred_count_q, mispred_count_d;

    logic              resolve;
    logic              cond;
    logic              mispredict;
    logic [PC_W-1:0]   target;

    // Direction decode and mispredict detection, purely combinational.
    always_comb begin
        resolve = ex_if.ex_valid & ex_if.ex_is_branch & ~kill_q & ~stall;
        brun    = ex_if.ex_funct3[2] & ex_if.ex_funct3[1];
        cond    = 1'b0;
        case (ex_if.ex_funct3)
            3'b000:         cond = breq;
            3'b001:         cond = ~breq;
            3'b100, 3'b110: cond = brlt;
            3'b101, 3'b111: cond = ~brlt;
            default:        cond = 1'b0;  // 010/011 are illegal and never taken
        endcase
        br_taken   = resolve & cond;
        mispredict = resolve & (cond != ex_if.ex_pred_taken);
        target     = cond ? (ex_if.ex_pc + ex_if.ex_imm) : (ex_if.ex_pc + PC_W'(4));
    end

    // Kill-window FSM and redirect generation.
    always_comb begin
        state_d          = state_q;
        kill_cnt_d       = kill_cnt_q;
        redirect_valid_d = mispredict;  // Always a single-cycle pulse, even under stall.
        redirect_pc_d    = redirect_pc_q;
        case (state_q)
            S_IDLE: begin
                if (mispredict) begin
                    state_d       = S_KILL;
                    kill_cnt_d    = KILL_INIT;
                    redirect_pc_d = target;
                end
            end
            S_KILL: begin
                if (!stall) begin
                    kill_cnt_d = kill_cnt_q - 3'd1;
                    if (kill_cnt_q == 3'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        kill_d = (state_d == S_KILL);
    end

    // Saturating statistics counters. A clear wins over an increment.
    always_comb begin
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (!stall) begin
            if (counter_clr) begin
                br_count_d      = '0;
                mispred_count_d = '0;
            end else begin
                if (resolve && (br_count_q != '1)) begin
                    br_count_d = br_count_q + CNT_W'(1);
                end
                if (mispredict && (mispred_count_q != '1)) begin
                    mispred_count_d = mispred_count_q + CNT_W'(1);
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            kill_cnt_q       <= '0;
            kill_q           <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            br_count_q       <= '0;
            mispred_count_q  <= '0;
        end else begin
            state_q          <= state_d;
            kill_cnt_q       <= kill_cnt_d;
            kill_q           <= kill_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            br_count_q       <= br_count_d;
            mispred_count_q  <= mispred_count_d;
        end
    end

    assign ex_if.redirect_valid = redirect_valid_q;
    assign ex_if.redirect_pc    = redirect_pc_q;
    assign ex_if.kill           = kill_q;
    assign br_count             = br_count_q;
    assign mispred_count        = mispred_count_q;
    assign state_dbg            = state_q;
endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: table of single-branch vectors, hand-written
// kill-window/stall, saturation and reset sequences, redirect scoreboard.
module tb_branch_resolve;
    localparam int PC_W    = 32;
    localparam int CNT_W   = 4;
    localparam int KC      = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             stall = 1'b0;
    logic             breq = 1'b0;
    logic             brlt = 1'b0;
    logic             counter_clr = 1'b0;
    logic             brun;
    logic             br_taken;
    logic             state_dbg;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;

    branch_resolve_if #(.PC_W(PC_W)) ex_if ();

    branch_resolve #(.PC_W(PC_W), .CNT_W(CNT_W), .KILL_CYCLES(KC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .ex_if         (ex_if),
        .brun          (brun),
        .breq          (breq),
        .brlt          (brlt),
        .counter_clr   (counter_clr),
        .br_taken      (br_taken),
        .br_count      (br_count),
        .mispred_count (mispred_count),
        .state_dbg     (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic        eq;
        logic        lt;
        logic        pred;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        exp_brun;
        logic        exp_taken;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t        vecs[12];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    int          exp_br = 0;
    int          exp_mp = 0;
    int          kill_high;
    logic        mis;
    logic        rnd_eq;
    logic [31:0] rnd_pc;
    logic [31:0] rnd_imm;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int sat(input int x);
        return (x > CNT_MAX) ? CNT_MAX : x;
    endfunction

    task automatic drive_br(input logic [2:0] f3, input logic eq, input logic lt,
                            input logic pred, input logic [31:0] pc, input logic [31:0] imm);
        ex_if.ex_valid      = 1'b1;
        ex_if.ex_is_branch  = 1'b1;
        ex_if.ex_funct3     = f3;
        ex_if.ex_pred_taken = pred;
        ex_if.ex_pc         = pc;
        ex_if.ex_imm        = imm;
        breq                = eq;
        brlt                = lt;
    endtask

    task automatic idle_inputs();
        ex_if.ex_valid      = 1'b0;
        ex_if.ex_is_branch  = 1'b0;
        ex_if.ex_funct3     = 3'b000;
        ex_if.ex_pred_taken = 1'b0;
        ex_if.ex_pc         = '0;
        ex_if.ex_imm        = '0;
        breq                = 1'b0;
        brlt                = 1'b0;
    endtask

    task automatic clear_counters();
        @(posedge clk); #1;
        counter_clr = 1'b1;
        @(posedge clk); #1;
        counter_clr = 1'b0;
        @(negedge clk);
        check("clr_br_count", br_count, 0);
        check("clr_mispred_count", mispred_count, 0);
        exp_br = 0;
        exp_mp = 0;
    endtask

    // Scoreboard: every redirect pulse must match the oldest expected target.
    always @(negedge clk) begin
        if (ex_if.redirect_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("redirect_unexpected", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("redirect_pc", ex_if.redirect_pc, mon_exp);
            end
        end
    end

    task automatic apply_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        @(posedge clk); #1;
        drive_br(v.f3, v.eq, v.lt, v.pred, v.pc, v.imm);
        @(negedge clk);
        check($sformatf("v%0d_brun", idx), brun, v.exp_brun);
        check($sformatf("v%0d_br_taken", idx), br_taken, v.exp_taken);
        mis = (v.exp_taken != v.pred);
        if (mis) exp_q.push_back(v.exp_pc);
        exp_br = sat(exp_br + 1);
        if (mis) exp_mp = sat(exp_mp + 1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check($sformatf("v%0d_redirect_valid", idx), ex_if.redirect_valid, mis);
        check($sformatf("v%0d_kill", idx), ex_if.kill, mis);
        check($sformatf("v%0d_br_count", idx), br_count, exp_br);
        check($sformatf("v%0d_mispred_count", idx), mispred_count, exp_mp);
        if (mis) begin
            for (int k = 2; k <= KC; k++) begin
                @(negedge clk);
                check($sformatf("v%0d_kill_hold", idx), ex_if.kill, 1);
            end
            @(negedge clk);
            check($sformatf("v%0d_kill_end", idx), ex_if.kill, 0);
        end
    endtask

    initial begin
        // f3, eq, lt, pred, pc, imm, exp_brun, exp_taken, exp_pc
        vecs[0]  = '{3'b100, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0040, 1'b0, 1'b1, 32'h0000_0140};
        vecs[1]  = '{3'b111, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_0010, 1'b1, 1'b0, 32'h0000_0204};
        vecs[2]  = '{3'b000, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0000_0020, 1'b0, 1'b1, 32'h0};
        vecs[3]  = '{3'b001, 1'b1, 1'b0, 1'b0, 32'h0000_0304, 32'h0000_0008, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{3'b001, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 32'hFFFF_FFF8, 1'b0, 1'b1, 32'h0000_02F8};
        vecs[5]  = '{3'b101, 1'b0, 1'b0, 1'b1, 32'h0000_0310, 32'h0000_0040, 1'b0, 1'b1, 32'h0};
        vecs[6]  = '{3'b110, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0000_0020, 1'b1, 1'b1, 32'h0000_0010};
        vecs[7]  = '{3'b010, 1'b1, 1'b1, 1'b1, 32'h0000_0400, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0404};
        vecs[8]  = '{3'b011, 1'b1, 1'b0, 1'b0, 32'h0000_0410, 32'h0000_0040, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{3'b010, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000};
        vecs[10] = '{3'b111, 1'b0, 1'b0, 1'b0, 32'h0000_0500, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0600};
        vecs[11] = '{3'b100, 1'b0, 1'b0, 1'b1, 32'h0000_0600, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0604};

        // Reset
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_redirect_valid", ex_if.redirect_valid, 0);
        check("rst_redirect_pc", ex_if.redirect_pc, 0);
        check("rst_kill", ex_if.kill, 0);
        check("rst_br_count", br_count, 0);
        check("rst_mispred_count", mispred_count, 0);
        check("rst_state", state_dbg, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Table-driven single branches
        for (int i = 0; i < 12; i++) apply_vec(i);

        // Wrong-path branch during KILL, plus a 3-cycle stall mid-window
        clear_counters();
        @(posedge clk); #1;
        drive_br(3'b000, 1'b0, 1'b0, 1'b1, 32'h0000_0700, 32'h0000_0080);
        exp_q.push_back(32'h0000_0704);
        kill_high = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            stall = (i >= 2 && i <= 4);
            if (i > 5) idle_inputs();
            @(negedge clk);
            if (ex_if.kill === 1'b1) kill_high++;
            if (i == 1) check("wrong_path_br_taken", br_taken, 0);
        end
        stall = 1'b0;
        idle_inputs();
        check("stall_kill_len", kill_high, KC + 3);
        check("wrong_path_br_count", br_count, 1);
        check("wrong_path_mispred_count", mispred_count, 1);

        // Saturation with 4-bit counters
        clear_counters();
        for (int n = 0; n < 20; n++) begin
            rnd_eq  = 1'($urandom_range(0, 1));
            rnd_pc  = $urandom() & 32'hFFFF_FFFC;
            rnd_imm = $urandom() & 32'h0000_FFFE;
            @(posedge clk); #1;
            drive_br(3'b000, rnd_eq, 1'b0, ~rnd_eq, rnd_pc, rnd_imm);
            exp_q.push_back(rnd_eq ? (rnd_pc + rnd_imm) : (rnd_pc + 32'd4));
            exp_br = sat(exp_br + 1);
            exp_mp = sat(exp_mp + 1);
            @(posedge clk); #1;
            idle_inputs();
            repeat (KC) @(posedge clk);
        end
        @(negedge clk);
        check("sat_br_count", br_count, exp_br);
        check("sat_mispred_count", mispred_count, exp_mp);
        check("sat_kill_idle", ex_if.kill, 0);

        // Clear together with a resolving branch
        @(posedge clk); #1;
        drive_br(3'b000, 1'b1, 1'b0, 1'b1, 32'h0000_0900, 32'h0000_0010);
        counter_clr = 1'b1;
        @(negedge clk);
        check("clr_resolve_br_taken", br_taken, 1);
        @(posedge clk); #1;
        counter_clr = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("clr_prio_br_count", br_count, 0);
        check("clr_prio_mispred_count", mispred_count, 0);
        check("clr_prio_kill", ex_if.kill, 0);

        // Reset in the cycle after a mispredict
        @(posedge clk); #1;
        drive_br(3'b001, 1'b1, 1'b0, 1'b1, 32'h0000_0800, 32'h0000_0040);
        exp_q.push_back(32'h0000_0804);
        @(posedge clk); #1;
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        check("prerst_redirect_valid", ex_if.redirect_valid, 1);
        check("prerst_kill", ex_if.kill, 1);
        check("prerst_br_count", br_count, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_kill", ex_if.kill, 0);
        check("midrst_redirect_valid", ex_if.redirect_valid, 0);
        check("midrst_br_count", br_count, 0);
        check("midrst_mispred_count", mispred_count, 0);
        check("midrst_state", state_dbg, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
